// File: rtl/game_pkg.sv
// Shared racing-game types and default road/steering geometry.
// The renderer imports the same defaults so road edges and clamps agree.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } dir_t;

    localparam int unsigned DEF_OFFSET_W    = 10;
    localparam int unsigned DEF_SCROLL_STEP = 2;
    localparam int unsigned DEF_LAT_W       = 10;
    localparam int unsigned DEF_LAT_MAX     = 200;
    localparam int unsigned DEF_VMAX        = 4;

    // Both buttons together cancel out to IDLE.
    function automatic dir_t dir_from_btns(input logic left, input logic right);
        dir_t dir;
        dir = IDLE;
        if (left && !right) begin
            dir = LEFT;
        end else if (right && !left) begin
            dir = RIGHT;
        end
        return dir;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw button.
// The output only toggles after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic btn_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_o = db_q;

endmodule

// File: rtl/steering_controller.sv
// Button conditioning plus per-frame road scroll and car lateral position update.
// Steering velocity ramps while a direction is held and is cleared on edge saturation.
module steering_controller
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned OFFSET_W        = DEF_OFFSET_W,
    parameter int unsigned SCROLL_STEP     = DEF_SCROLL_STEP,
    parameter int unsigned LAT_W           = DEF_LAT_W,
    parameter int unsigned LAT_MAX         = DEF_LAT_MAX,
    parameter int unsigned VMAX            = DEF_VMAX
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    left_btn,
    input  logic                    right_btn,
    input  logic                    frame_pulse,
    output logic [OFFSET_W-1:0]     frame_offset,
    output logic signed [LAT_W-1:0] lateral_offset,
    output logic                    steer_left,
    output logic                    steer_right
);

    localparam int unsigned VEL_W = $clog2(VMAX + 1);
    localparam logic [VEL_W-1:0] VEL_MAX = VEL_W'(VMAX);
    localparam logic signed [LAT_W:0] LAT_HI = (LAT_W + 1)'(LAT_MAX);
    localparam logic signed [LAT_W:0] LAT_LO = -LAT_HI;

    logic                    fp_q;
    logic [OFFSET_W-1:0]     frame_offset_q;
    logic [OFFSET_W-1:0]     frame_offset_d;
    logic signed [LAT_W-1:0] lateral_q;
    logic signed [LAT_W-1:0] lateral_d;
    logic [VEL_W-1:0]        vel_q;
    logic [VEL_W-1:0]        vel_d;
    dir_t                    last_dir_q;
    dir_t                    last_dir_d;

    dir_t                    dir;
    logic                    frame_edge;
    logic [VEL_W-1:0]        vel_ramp;
    logic signed [LAT_W:0]   lat_ext;
    logic signed [LAT_W:0]   vel_ext;
    logic signed [LAT_W:0]   lat_sum;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left_db (
        .clk  (clk),
        .reset(reset),
        .btn_i(left_btn),
        .btn_o(steer_left)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right_db (
        .clk  (clk),
        .reset(reset),
        .btn_i(right_btn),
        .btn_o(steer_right)
    );

    always_comb begin
        frame_offset_d = frame_offset_q;
        lateral_d      = lateral_q;
        vel_d          = vel_q;
        last_dir_d     = last_dir_q;

        // Registered debounced levels: a same-cycle debounce change waits a frame.
        dir        = dir_from_btns(steer_left, steer_right);
        frame_edge = frame_pulse & ~fp_q;

        if (dir == IDLE) begin
            vel_ramp = '0;
        end else if (dir != last_dir_q) begin
            vel_ramp = VEL_W'(1);
        end else if (vel_q >= VEL_MAX) begin
            vel_ramp = VEL_MAX;
        end else begin
            vel_ramp = vel_q + 1'b1;
        end

        // One extra bit so the sum cannot wrap before the clamp test.
        lat_ext = {lateral_q[LAT_W-1], lateral_q};
        vel_ext = {{(LAT_W + 1 - VEL_W){1'b0}}, vel_ramp};
        lat_sum = (dir == LEFT) ? (lat_ext - vel_ext) : (lat_ext + vel_ext);

        if (frame_edge) begin
            frame_offset_d = frame_offset_q + OFFSET_W'(SCROLL_STEP);
            last_dir_d     = dir;
            vel_d          = vel_ramp;
            if (lat_sum > LAT_HI) begin
                lateral_d = LAT_HI[LAT_W-1:0];
                vel_d     = '0;
            end else if (lat_sum < LAT_LO) begin
                lateral_d = LAT_LO[LAT_W-1:0];
                vel_d     = '0;
            end else begin
                lateral_d = lat_sum[LAT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fp_q           <= 1'b0;
            frame_offset_q <= '0;
            lateral_q      <= '0;
            vel_q          <= '0;
            last_dir_q     <= IDLE;
        end else begin
            fp_q           <= frame_pulse;
            frame_offset_q <= frame_offset_d;
            lateral_q      <= lateral_d;
            vel_q          <= vel_d;
            last_dir_q     <= last_dir_d;
        end
    end

    assign frame_offset   = frame_offset_q;
    assign lateral_offset = lateral_q;

endmodule

// File: doc/steering_controller.md
Name: steering_controller

Overview:
Input-side stage of the racing game, directly upstream of the VGA renderer. It synchronises and debounces the left/right buttons. On each frame boundary it advances the road scroll position `frame_offset` and updates the car's `lateral_offset` with ramped steering velocity and saturation at the road edges. The renderer consumes both offsets; `frame_pulse` comes from the VGA timing generator (one pulse per frame, at vsync start).

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive stable clk cycles required before a debounced button changes (1 ms at 100 MHz)
- OFFSET_W, 10, width of frame_offset
- SCROLL_STEP, 2, frame_offset increment per frame
- LAT_W, 10, width of signed lateral_offset
- LAT_MAX, 200, lateral saturation bound; legal range is -LAT_MAX..+LAT_MAX (must be < 2^(LAT_W-1))
- VMAX, 4, maximum steering velocity in pixels/frame

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- left_btn, input, 1, raw asynchronous left button
- right_btn, input, 1, raw asynchronous right button
- frame_pulse, input, 1, frame boundary strobe from VGA timing
- frame_offset, output, OFFSET_W, road scroll position
- lateral_offset, output, LAT_W (signed), car horizontal offset from centre; positive = right
- steer_left, output, 1, debounced left button
- steer_right, output, 1, debounced right button

Behaviour:
- Reset (async assert, sync release by design):
  - frame_offset=0, lateral_offset=0, steer_left=0, steer_right=0
  - velocity=0, last_dir=IDLE
  - synchroniser flops=0, debounce counters=0, frame_pulse history=0
- Synchroniser: each button passes through a 2-flop chain before debounce.
- Debounce, per button:
  - counter increments while the synced value differs from the debounced output, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the debounced output toggles and the counter clears.
  - Press-to-steer latency = 2 sync cycles + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES causes no change.
- Frame update:
  - Fires on the rising edge of frame_pulse (registered previous value). A pulse held high for several cycles updates once.
  - Outputs change on the clk edge after the cycle in which the edge is detected (1-cycle latency).
- Direction, sampled at the update:
  - LEFT if steer_left & ~steer_right.
  - RIGHT if steer_right & ~steer_left.
  - Otherwise IDLE (both pressed = IDLE).
- Velocity FSM, states IDLE/LEFT/RIGHT held in last_dir:
  - dir IDLE: vel=0.
  - dir differs from last_dir (including a reversal): vel=1.
  - dir equals last_dir: vel=min(vel+1, VMAX).
  - last_dir <= dir.
- Position:
  - lateral_next = lateral ± vel_next, computed at LAT_W+1 bits and saturated to ±LAT_MAX.
  - On saturation, vel is cleared to 0 for that frame; the next frame with the same direction uses vel=1, and the position stays clamped.
- Scroll: frame_offset <= frame_offset + SCROLL_STEP, modulo 2^OFFSET_W (natural wrap, no flag).
- Simultaneous events: a debounced button change in the same cycle as the frame edge is not seen until the next frame. The update uses the registered steer_* values from before that edge.
- Reset mid-press or mid-frame: everything returns to the reset values immediately. A button still held after release of reset must re-debounce fully.

Decomposition:
- Shared package `game_pkg`:
  - dir_t enum (IDLE=2'd0, LEFT=2'd1, RIGHT=2'd2)
  - default constants for LAT_MAX, VMAX, SCROLL_STEP, OFFSET_W, LAT_W, which the renderer also uses for road geometry
- Sub-module `btn_debounce` (synchroniser + counter, parameter DEBOUNCE_CYCLES), instantiated twice.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SCROLL_STEP=2, LAT_MAX=10, VMAX=4, OFFSET_W=4; frame_pulse is 1 cycle every 50 cycles):
- Reset for 5 cycles, then idle for 3 frames -> lateral_offset=0, frame_offset=0,2,4,6 after each frame's +1-cycle latency; steer_*=0 throughout.
- right_btn pulse 3 cycles long -> steer_right never asserts; lateral stays 0. right_btn held -> steer_right=1 exactly 6 cycles after the press.
- right held over 5 frames -> lateral = 1,3,6,10,10 (vel 1,2,3,4, then clamp with vel=0); next frame lateral=10 (vel=1, clamped).
- Right held to lateral=6 (vel=3), then switch to left -> next frame vel=1, lateral=5; following frame lateral=3.
- Both buttons held -> lateral unchanged and vel=0; frame_offset wraps 14 -> 0.
- Assert reset asynchronously between clock edges while lateral=-7 and right is debounced -> all outputs 0 immediately, without waiting for a clk edge. frame_pulse held high for 3 cycles -> a single update, frame_offset +2 only.
